spi_ram_host_seq: RTL and testbench

Host-side SPI sequencer that drives the Spi_Ram slave (SPI slave plus single-port RAM) over MOSI/MISO/SS_n. It accepts parallel read/write requests on a valid/ready interface and issues the two-frame SPI protocol for each one. A write is sent as WR_ADDR then WR_DATA. A read is sent as RD_ADDR then RD_DATA, after which the sequencer captures the 8-bit read data from MISO and returns it on a response strobe. It shares the system clock with Spi_Ram, so it is a single-clock design.

---
 rtl/spi_ram_host_seq.sv | 109 ++++++++++
 tb/tb_spi_ram_host_seq.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/spi_ram_host_seq.sv
// spi_ram_host_seq: host sequencer issuing two-frame SPI transactions to an Spi_Ram slave
// Ports: clk/rstn (async active-low); req_valid/req_ready/req_wr/req_addr/req_wdata request in;
// rsp_valid/rsp_rdata read response; busy; SS_n/MOSI/MISO serial link to the slave.
module spi_ram_host_seq #(
  parameter int GAP_CYCLES = 2,
  parameter int RD_WAIT    = 1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_wr,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);
  typedef enum logic [2:0] {IDLE, START, SEL, SHIFT, RWAIT, CAPT, GAP} state_e;
  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       ph_q, ph_d, wr_q, wr_d;
  logic [7:0] addr_q, addr_d, wdata_q, wdata_d, cap_q, cap_d;
  logic       req_ready_q, req_ready_d, busy_q, busy_d, rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_rdata_q, rsp_rdata_d;
  logic       ss_n_q, ss_n_d, mosi_q, mosi_d;
  logic [9:0] frame;
  logic       last_capt;
  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign SS_n      = ss_n_q;
  assign MOSI      = mosi_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ph_q        <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cap_q       <= '0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      ss_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ph_q        <= ph_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cap_q       <= cap_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      ss_n_q      <= ss_n_d;
      mosi_q      <= mosi_d;
    end
  end
  // One shared cycle counter restarts at 0 on every state change.
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: if (req_valid && req_ready_q) begin
        state_d = START;
        ph_d    = 1'b0;
        wr_d    = req_wr;
        addr_d  = req_addr;
        wdata_d = req_wdata;
      end
      START: state_d = SEL;
      SEL:   state_d = SHIFT;
      SHIFT: if (cnt_q == 4'd9) state_d = (ph_q && !wr_q) ? ((RD_WAIT == 0) ? CAPT : RWAIT) : GAP;
      RWAIT: if (cnt_q == 4'(RD_WAIT - 1)) state_d = CAPT;
      CAPT:  if (cnt_q == 4'd7) state_d = GAP;
      GAP: if (cnt_q == 4'(GAP_CYCLES - 1)) begin
        state_d = ph_q ? IDLE : START;
        ph_d    = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    cnt_d = (state_d != state_q) ? 4'd0 : cnt_q + 4'd1;
  end
  // Outputs are decoded from the next state so the registered pins line up with the state they belong to.
  always_comb begin
    frame       = {~wr_q, ph_q, ph_q ? (wr_q ? wdata_q : 8'h00) : addr_q};
    last_capt   = (state_q == CAPT) && (cnt_q == 4'd7);
    cap_d       = (state_q == CAPT) ? {cap_q[6:0], MISO} : cap_q;
    rsp_valid_d = last_capt;
    rsp_rdata_d = last_capt ? cap_d : rsp_rdata_q;
    ss_n_d      = (state_d == IDLE) || (state_d == GAP);
    req_ready_d = state_d == IDLE;
    busy_d      = state_d != IDLE;
    mosi_d      = (state_d == SEL) ? ~wr_q : (state_d == SHIFT) ? frame[4'd9 - cnt_d] : 1'b0;
  end
endmodule

// File: tb/tb_spi_ram_host_seq.sv
// tb_spi_ram_host_seq: directed bench with a behavioural Spi_Ram slave and frame/read-data scoreboards
module tb_spi_ram_host_seq;
  localparam int GAP = 2;
  localparam int RW  = 1;
  logic       clk = 1'b0, rstn = 1'b0, req_valid = 1'b0, req_wr = 1'b0, MISO = 1'b0;
  logic [7:0] req_addr = '0, req_wdata = '0;
  logic       req_ready, rsp_valid, busy, SS_n, MOSI;
  logic [7:0] rsp_rdata;
  int n_assert = 0, n_fail = 0;
  always #5 clk = ~clk;
  spi_ram_host_seq #(.GAP_CYCLES(GAP), .RD_WAIT(RW)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .busy(busy), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  logic [11:0] exp_f [$];
  logic [7:0]  exp_rd [$];
  logic [7:0]  mem [256] = '{default: 8'h00};
  logic [4:0]  k = '0;
  logic [10:0] sr = '0;
  logic [7:0]  sa = '0, rbyte = '0;
  logic        rd = 1'b0;
  // Slave model: indexes each SS_n-low cycle, decodes the 12-bit window at index 11, and drives read data
  // during the capture window that follows RD_DATA.
  always @(negedge clk) begin
    if (SS_n) begin
      k <= '0;
      rd <= 1'b0;
      MISO <= 1'b0;
    end else begin
      k <= k + 5'd1;
      sr <= {sr[9:0], MOSI};
      if (k == 5'd11) begin
        chk("frame", {sr, MOSI}, exp_f.size() != 0 ? exp_f.pop_front() : 12'hFFF);
        case (sr[8:7])
          2'b00, 2'b10: sa <= {sr[6:0], MOSI};
          2'b01: mem[sa] <= {sr[6:0], MOSI};
          default: begin
            rbyte <= mem[sa];
            rd <= 1'b1;
          end
        endcase
      end
      MISO <= (rd && k >= 5'(12 + RW) && k <= 5'(19 + RW)) ? rbyte[3'(19 + RW - int'(k))] : 1'b0;
    end
  end
  int hi_cnt = 0, last_gap = 0, rv_w = 0;
  always @(negedge clk) begin
    if (SS_n) hi_cnt <= hi_cnt + 1;
    else if (hi_cnt != 0) begin
      last_gap <= hi_cnt;
      hi_cnt <= 0;
    end
  end
  always @(negedge clk) begin
    if (rsp_valid) begin
      rv_w <= rv_w + 1;
      chk("rsp_rdata", rsp_rdata, exp_rd.size() != 0 ? 32'(exp_rd.pop_front()) : 32'h1FF);
    end else if (rv_w != 0) begin
      chk("rsp_width", rv_w, 1);
      rv_w <= 0;
    end
  end
  task automatic push_exp(input logic wr, input logic [7:0] a, input logic [7:0] d);
    exp_f.push_back({1'b0, ~wr, ~wr, 1'b0, a});
    exp_f.push_back({1'b0, ~wr, ~wr, 1'b1, wr ? d : 8'h00});
    if (!wr) exp_rd.push_back(d);
  endtask
  task automatic wait_ready(input string tag, input int lat);
    int n = 0;
    while (!req_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(tag, n, lat);
  endtask
  // For reads d is the expected read data; the wdata pin carries junk that must not appear on MOSI.
  task automatic req(input logic wr, input logic [7:0] a, input logic [7:0] d, input int lat);
    push_exp(wr, a, d);
    @(negedge clk);
    req_valid = 1'b1;
    req_wr = wr;
    req_addr = a;
    req_wdata = wr ? d : 8'h5A;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_wr = ~wr;
    req_addr = ~a;
    req_wdata = ~d;
    chk("accept", {busy, req_ready}, 2'b10);
    wait_ready(wr ? "wr_latency" : "rd_latency", lat);
  endtask
  initial begin
    @(negedge clk);
    chk("rst_ss_n", SS_n, 1'b1);
    chk("rst_mosi", MOSI, 1'b0);
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 8'h00);
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_ss_n", SS_n, 1'b1);
    chk("idle_ready", req_ready, 1'b1);
    req(1'b1, 8'hD5, 8'h95, 28);
    chk("mem_d5", mem[8'hD5], 8'h95);
    req(1'b0, 8'hD5, 8'h95, 37);
    req(1'b0, 8'h87, 8'h00, 37);
    chk("rdata_hold", rsp_rdata, 8'h00);
    push_exp(1'b1, 8'h10, 8'hAA);
    push_exp(1'b0, 8'h10, 8'hAA);
    @(negedge clk);
    req_valid = 1'b1;
    req_wr = 1'b1;
    req_addr = 8'h10;
    req_wdata = 8'hAA;
    @(posedge clk);
    #1;
    req_wr = 1'b0;
    req_wdata = 8'h33;
    chk("b2b_accept1", {busy, req_ready}, 2'b10);
    wait_ready("b2b_wr_latency", 28);
    @(posedge clk);
    #1;
    chk("b2b_accept2", {busy, req_ready}, 2'b10);
    req_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("b2b_gap", last_gap, GAP + 1);
    wait_ready("b2b_rd_latency", 37);
    push_exp(1'b1, 8'hD5, 8'h3C);
    @(negedge clk);
    req_valid = 1'b1;
    req_wr = 1'b1;
    req_addr = 8'hD5;
    req_wdata = 8'h3C;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    chk("pre_rst_ss_n", SS_n, 1'b0);
    rstn = 1'b0;
    #1;
    chk("midrst_ss_n", SS_n, 1'b1);
    chk("midrst_state", {busy, req_ready, MOSI}, 3'b010);
    void'(exp_f.pop_back());
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    req(1'b0, 8'hD5, 8'h95, 37);
    repeat (3) @(negedge clk);
    chk("frames_left", exp_f.size(), 0);
    chk("rsp_left", exp_rd.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
